// File: rtl/axis_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_adder_pkg                                                       |
// | Shared types, FSM encoding and parameter checks for axis_adder_tx.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package axis_adder_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t MID  = 1'b1;

    // Sum of two unsigned operands needs one carry bit.
    function automatic int sum_width(input int c_w);
        return c_w + 1;
    endfunction

    function automatic bit params_ok(input int c_w, input int data_w, input int keep_w,
                                     input int depth, input int frame_len);
        return (c_w >= 1) && (data_w >= c_w + 1) && (keep_w == (data_w + 7) / 8) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0) && (frame_len >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_adder_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_adder_tx_fifo                                                   |
// | First-word-fall-through result buffer with occupancy count.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_adder_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign empty   = (r_level == '0);
    assign full    = (r_level == c_FULL_LVL);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // A read in the same cycle frees the slot, so a full buffer still accepts.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/axis_adder_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_adder_tx                                                        |
// | Sums operand pairs, buffers them and emits fixed-length AXIS frames. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_adder_tx
    import axis_adder_pkg::*;
#(
    parameter int c_WIDTH    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int DEPTH      = 8,
    parameter int FRAME_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [c_WIDTH-1:0]      value_a,
    input  logic [c_WIDTH-1:0]      value_b,
    input  logic                    in_valid,
    input  logic                    flush,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    status_overflow,
    output logic                    status_frame_sent,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int SUM_WIDTH = sum_width(c_WIDTH);
    localparam int c_LVL_W   = $clog2(DEPTH) + 1;
    localparam int c_CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(FRAME_LEN - 1);

    if (!params_ok(c_WIDTH, DATA_WIDTH, KEEP_WIDTH, DEPTH, FRAME_LEN)) begin : g_bad_params
        $error("axis_adder_tx: illegal parameter combination");
    end

    logic                  r_s1_valid;
    logic [SUM_WIDTH-1:0]  r_s1_sum;
    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic [DATA_WIDTH-1:0] w_sum_ext;

    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_full;
    logic                  w_empty;
    logic [c_LVL_W-1:0]    w_level;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_pend;
    logic                  r_err;
    logic                  r_err_late;
    logic                  r_stall;
    logic                  r_tlast_q;

    logic                  w_tvalid;
    logic                  w_xfer;
    logic                  w_at_last;
    logic                  w_tlast_new;
    logic                  w_tlast;
    logic                  w_tlast_xfer;
    logic                  w_ovf;
    logic                  w_started;

    always_comb begin
        w_sum_ext                = '0;
        w_sum_ext[SUM_WIDTH-1:0] = r_s1_sum;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) r_s1_sum <= {1'b0, value_a} + {1'b0, value_b};
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_sum_ext;
        end
    end

    axis_adder_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (r_s2_valid),
        .wr_data (r_s2_data),
        .rd_en   (w_xfer),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .level   (w_level)
    );

    assign w_tvalid  = !w_empty;
    assign w_xfer    = w_tvalid && m_axis_tready;
    assign w_at_last = (r_count == c_LAST_CNT);
    assign w_started = (r_state == MID) || w_tvalid;
    assign w_ovf     = r_s2_valid && w_full && !w_xfer;

    // While stalled, the presented tlast is frozen: a late flush or a new write
    // changing the level must not alter a beat the sink has already seen.
    assign w_tlast_new  = w_tvalid && (w_at_last || (r_pend && (w_level == c_LVL_W'(1))));
    assign w_tlast      = r_stall ? r_tlast_q : w_tlast_new;
    assign w_tlast_xfer = w_xfer && w_tlast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_stall    <= 1'b0;
            r_tlast_q  <= 1'b0;
        end else begin
            r_stall   <= w_tvalid && !m_axis_tready;
            r_tlast_q <= w_tlast;

            if (w_tlast_xfer)  r_count <= '0;
            else if (w_xfer)   r_count <= r_count + c_CNT_W'(1);

            case (r_state)
                IDLE:    if (w_xfer && !w_tlast) r_state <= MID;
                MID:     if (w_tlast_xfer)       r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_tlast_xfer)
                r_pend <= 1'b0;
            else if (flush && w_started && !w_at_last)
                r_pend <= 1'b1;
        end
    end

    // Drops seen once the tlast beat is on the bus belong to the next frame,
    // which keeps tuser stable for the beat being offered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_late <= 1'b0;
        end else if (w_tlast_xfer) begin
            r_err      <= w_ovf || r_err_late;
            r_err_late <= 1'b0;
        end else if (w_ovf) begin
            if (w_tlast) r_err_late <= 1'b1;
            else         r_err      <= 1'b1;
        end
    end

    assign m_axis_tvalid     = w_tvalid;
    assign m_axis_tdata      = w_tvalid ? w_rd_data : '0;
    assign m_axis_tkeep      = {KEEP_WIDTH{w_tvalid}};
    assign m_axis_tlast      = w_tlast;
    assign m_axis_tuser      = w_tlast && r_err;
    assign status_overflow   = w_ovf;
    assign status_frame_sent = w_tlast_xfer;
    assign level             = w_level;

endmodule
`default_nettype wire

// File: doc/axis_adder_tx.md
Name: axis_adder_tx

Overview:
AXI4-Stream transmitter for adder results. Each strobed operand pair (value_a, value_b) is summed, buffered in a small internal FIFO, and emitted on an AXIS master port as fixed-length frames. It is the source end of the result stream, and is intended to feed the stream-FIFO path of the adder toplevel or any downstream AXIS sink. Backpressure is absorbed by the buffer. Samples arriving while the buffer is full are dropped and reported.

Parameters:
c_WIDTH, 4, operand width; sum is c_WIDTH+1 bits
DATA_WIDTH, 8, m_axis_tdata width; must be >= c_WIDTH+1 (elaboration error otherwise)
KEEP_WIDTH, 1, tkeep width; (DATA_WIDTH+7)/8
DEPTH, 8, result buffer entries; power of two, >= 2
FRAME_LEN, 4, beats per frame; >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
value_a  in  c_WIDTH  operand A, unsigned
value_b  in  c_WIDTH  operand B, unsigned
in_valid  in  1  operand pair valid this cycle; no ready, never stalled
flush  in  1  single-cycle request to terminate the current frame early
m_axis_tdata  out  DATA_WIDTH  zero-extended sum
m_axis_tkeep  out  KEEP_WIDTH  all ones
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
m_axis_tlast  out  1  last beat of frame
m_axis_tuser  out  1  bad-frame flag, valid on tlast beat only, 0 elsewhere
status_overflow  out  1  one-cycle pulse per dropped sample
status_frame_sent  out  1  one-cycle pulse when a tlast beat is accepted
level  out  $clog2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset (rst low, async assert, sync deassert): all outputs 0, buffer empty, beat counter 0, error flag 0, pending-flush 0, FSM in IDLE.
- Stage 1: on in_valid, register sum = value_a + value_b as a (c_WIDTH+1)-bit value with no truncation. Stage 2: write the sum into the buffer on the following edge.
- Latency: in_valid sampled at edge k, buffer empty and tready high -> tvalid high after edge k+2.
- Buffer full at a stage-2 write with no simultaneous read: sample is dropped, status_overflow pulses, and the error flag is set. Full with a simultaneous read: write is accepted.
- Handshake: a beat transfers when tvalid && tready. tvalid = buffer not empty. tdata, tlast and tuser are held stable while tvalid && !tready. tvalid is never deasserted without a transfer.
- Beat counter counts transferred beats, 0..FRAME_LEN-1. tlast = (count == FRAME_LEN-1) || (pending-flush && level == 1). The counter returns to 0 on a tlast transfer.
- flush sets pending-flush if the current frame has started (count > 0 or buffer non-empty). Pending-flush clears on the tlast transfer. flush with no data is ignored. If flush arrives while count == FRAME_LEN-1, the frame ends normally.
- tuser = error flag on the tlast beat. The error flag clears on the tlast transfer. An overflow in the same cycle as a tlast transfer sets the flag for the next frame.
- FSM has two states:
  - IDLE (count == 0): goes to MID on the first beat transfer, unless that beat is also tlast.
  - MID: goes to IDLE on a tlast transfer.
- FRAME_LEN == 1: every beat has tlast set.
- level updates every cycle. Simultaneous read and write leave level unchanged. Pointers wrap modulo DEPTH.
- status_frame_sent pulses in the cycle the tlast beat transfers.

Decomposition:
- Shared package axis_adder_pkg holds:
  - SUM_WIDTH = c_WIDTH+1
  - the FSM state typedef (IDLE, MID)
  - the parameter-legality check function
- One sub-module, axis_adder_tx_fifo: synchronous FWFT buffer with DATA_WIDTH, DEPTH, full, empty and level.

Test Plan:
1. Reset mid-frame: 2 of 4 beats sent, then assert rst -> tvalid = 0 and level = 0 immediately. After release, the next frame starts at count 0.
2. Streaming with tready = 1: pairs (3,4), (15,15), (0,0), (8,9) -> tdata 7, 30, 0, 17; tlast on the 4th beat; tuser = 0; one status_frame_sent pulse.
3. Backpressure: tready = 0 for 20 cycles while 10 pairs of (1,1) arrive, DEPTH = 8 -> level saturates at 8 and status_overflow pulses twice. On release, 8 beats of tdata 2 are sent, and tuser = 1 on the first tlast beat only.
4. Early termination: 2 beats of (5,5) buffered, then flush -> 2nd beat carries tlast and the counter resets. A subsequent frame is 4 beats long.
5. tready toggling every cycle: tdata, tlast and tuser remain stable while stalled, and sums arrive in order with no duplicates or gaps.
6. Boundary: full buffer, simultaneous read and write -> no overflow pulse and level stays 8. FRAME_LEN = 1 build -> tlast on every beat.
